// File: rtl/rx_byte_fifo_pkg.sv
// Shared definitions for the receive path.
// Capture FSM encodings, FIFO entry layout and default depth.
package rx_byte_fifo_pkg;

    localparam int RX_FIFO_DEPTH_LOG2 = 3;
    localparam int RX_ENTRY_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } capState_t;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rxEntry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Receive FIFO storage array.
// Synchronous write, asynchronous read, no reset.
module rx_fifo_mem
    import rx_byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
    parameter int WIDTH      = RX_ENTRY_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wAddr,
    input  logic [WIDTH-1:0]      wData,
    input  logic [DEPTH_LOG2-1:0] rAddr,
    output logic [WIDTH-1:0]      rData
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on a push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= wData;
        end
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO with receiver handshake capture.
// Captures bytes/errors, acks the receiver, buffers FWFT.
module rx_byte_fifo
    import rx_byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [7:0]          rxData,
    input  logic                rxDataReady,
    input  logic                rxFrameError,
    input  logic                rxOverrun,
    output logic                ackFlags,
    output logic [7:0]          outData,
    output logic                outError,
    output logic                outValid,
    input  logic                outReady,
    input  logic                flush,
    input  logic                clearStatus,
    output logic [DEPTH_LOG2:0] count,
    output logic                fifoOverflow,
    output logic                rxLost
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    capState_t state;
    capState_t stateNext;
    logic      capture;

    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  full;
    logic                  doPush;
    logic                  doPop;
    logic                  overflowSet;
    rxEntry_t              wrEntry;
    rxEntry_t              rdEntry;

    // Capture FSM next state; capture only from IDLE.
    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxDataReady || rxFrameError) begin
                    capture   = 1'b1;
                    stateNext = ACK;
                end
            end
            ACK: begin
                stateNext = WAIT;
            end
            WAIT: begin
                if (!rxDataReady && !rxFrameError) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Capture FSM state and the one-cycle acknowledge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            ackFlags <= 1'b0;
        end else begin
            state    <= stateNext;
            ackFlags <= capture;
        end
    end

    assign full        = (count == FULL_COUNT);
    assign outValid    = (count != '0);
    assign doPush      = capture && !full && !flush;
    assign doPop       = outValid && outReady && !flush;
    assign overflowSet = capture && full && !flush;

    assign wrEntry.err  = rxFrameError;
    assign wrEntry.data = rxData;

    // Pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count
                   + (DEPTH_LOG2 + 1)'(doPush)
                   - (DEPTH_LOG2 + 1)'(doPop);
        end
    end

    // Sticky status; a same-edge set beats clearStatus.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            fifoOverflow <= 1'b0;
            rxLost       <= 1'b0;
        end else begin
            if (overflowSet) begin
                fifoOverflow <= 1'b1;
            end else if (clearStatus) begin
                fifoOverflow <= 1'b0;
            end
            if (rxOverrun) begin
                rxLost <= 1'b1;
            end else if (clearStatus) begin
                rxLost <= 1'b0;
            end
        end
    end

    rx_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (RX_ENTRY_W)
    ) uMem (
        .clk  (clk),
        .we   (doPush),
        .wAddr(wrPtr),
        .wData(wrEntry),
        .rAddr(rdPtr),
        .rData(rdEntry)
    );

    assign outData  = rdEntry.data;
    assign outError = rdEntry.err;

endmodule
